// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// the FSM state encoding and the default operand width.
package serial_addsub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CW    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_add1.sv
// Single-bit full adder cell.
// The serial engine reuses this one cell for every bit position.
module add1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract engine: one add1 cell, one bit per clock, LSB first.
// Uses a start/busy/done handshake, and the result is held until the next accepted start.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = DEFAULT_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s, co;

    add1 u_add1 (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .ci (c_q),
        .s  (s),
        .co (co)
    );

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
                    opa_d      = a;
                    opb_d      = b ^ {WIDTH{sub}};
                    c_d        = sub;
                    cnt_d      = '0;
                    acc_d      = '0;
                    result_d   = '0;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = {s, acc_q[WIDTH-1:1]};
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                c_d   = co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // On the MSB, c_q is the carry into the MSB and co is the carry out of it.
                    result_d   = {s, acc_q[WIDTH-1:1]};
                    carry_d    = co;
                    overflow_d = c_q ^ co;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that they come straight off flops.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: stimulus pushes expected results,
// and a monitor pops and compares them on every done pulse.
module tb_serial_addsub_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    serial_addsub_ctrl #(.WIDTH(W), .CW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a_in),
        .b        (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference works on wide integers, so carry and overflow fall out of range tests.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t              e;
        longint unsigned   ux;
        longint unsigned   uy;
        longint unsigned   usum;
        longint            sx;
        longint            sy;
        longint            sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            usum = ux + uy;
            e.res = usum[W-1:0];
            e.c   = usum[W];
            sr    = sx + sy;
        end else begin
            usum = ux - uy;
            e.res = usum[W-1:0];
            e.c   = (ux >= uy);
            sr    = sx - sy;
        end
        e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) checkOutput("busy_and_done", {busy, done}, 2'b10);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result", result, e.res);
                    checkOutput("carry", carry, e.c);
                    checkOutput("overflow", overflow, e.ov);
                end
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the edge that leaves DONE.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 input bit intrude);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   seen;
        e     = model(x, y, s);
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        sub   = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        sub   = 1'($urandom);
        exp_q.push_back(e);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (intrude && lat == 10) begin
                start = 1'b1;
                a_in  = 1;
                b_in  = 1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (!seen) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("latency", lat, W);
            checkOutput("busy_cycles", busy_cnt, W);
        end
        if (intrude) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("hold_result", result, e.res);
        checkOutput("idle_busy", {busy, done}, 2'b00);
    endtask

    initial begin
        exp_t dummy;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {busy, done, result, carry, overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(32'd5, 32'd7, 1'b0, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'd3, 32'd5, 1'b1, 1'b0);
        applyStimulus(32'd5, 32'd3, 1'b1, 1'b0);
        applyStimulus(32'h80000000, 32'd1, 1'b1, 1'b0);
        applyStimulus(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b1);
        applyStimulus(32'd9, 32'd9, 1'b1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            applyStimulus($urandom, $urandom, 1'($urandom), (n % 5) == 0);
        end

        // Abort an operation partway through; it must never produce a done pulse.
        start = 1'b1;
        a_in  = 32'hDEADBEEF;
        b_in  = 32'h01234567;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_outputs", {busy, done, result}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'd1, 32'd1, 1'b0, 1'b0);
        dummy = model(32'd1, 32'd1, 1'b0);
        checkOutput("after_abort", result, dummy.res);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
